// File: rtl/vbuff_writer_if.sv
// ---------------------------------------------------------------------------
// vbuff_writer_if
// Bundles the pixel-stream input and the frame-buffer write bus of
// vbuff_writer.
//   row_i / col_i  : 16-bit coordinate of the incoming pixel
//   valid_i        : qualifies row_i, col_i and pixel_i
//   pixel_i        : incoming pixel value (PIXEL_W bits)
//   swap_i         : one-cycle bank-swap grant from the reader
//   w_addr_o       : frame-buffer write address (AW bits)
//   w_data_o       : frame-buffer write data (PIXEL_W bits)
//   w_en_o         : frame-buffer write strobe
// master = pixel source / buffer side, slave = the writer itself.
// ---------------------------------------------------------------------------
interface vbuff_writer_if #(
    parameter int PIXEL_W = 12,
    parameter int AW      = 20
);
    logic [15:0]        row_i;
    logic [15:0]        col_i;
    logic               valid_i;
    logic [PIXEL_W-1:0] pixel_i;
    logic               swap_i;
    logic [AW-1:0]      w_addr_o;
    logic [PIXEL_W-1:0] w_data_o;
    logic               w_en_o;

    modport master (
        output row_i, col_i, valid_i, pixel_i, swap_i,
        input  w_addr_o, w_data_o, w_en_o
    );

    modport slave (
        input  row_i, col_i, valid_i, pixel_i, swap_i,
        output w_addr_o, w_data_o, w_en_o
    );
endinterface

// File: rtl/vbuff_writer.sv
// ---------------------------------------------------------------------------
// vbuff_writer
// Writes a raster-ordered pixel stream into one bank of a double-buffered
// frame store. When a frame completes the writer parks in FULL until the
// reader grants a swap, then flips banks and waits for the next (0,0).
//   pclk         : sole clock, rising edge
//   rst_i        : synchronous active-high reset
//   bus          : pixel input + frame-buffer write port (slave modport)
//   wr_bank_o    : bank currently being written
//   rd_bank_o    : bank the reader uses (always ~wr_bank_o)
//   frame_done_o : one-cycle pulse alongside the last pixel's write
//   err_range_o  : sticky, out-of-range coordinate seen
//   err_order_o  : sticky, non-raster-order coordinate seen
//   drop_cnt_o   : frames dropped while FULL, saturating at 255
// ---------------------------------------------------------------------------
module vbuff_writer #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int PIXEL_W = 12
) (
    input  logic                pclk,
    input  logic                rst_i,
    vbuff_writer_if.slave       bus,
    output logic                wr_bank_o,
    output logic                rd_bank_o,
    output logic                frame_done_o,
    output logic                err_range_o,
    output logic                err_order_o,
    output logic [7:0]          drop_cnt_o
);
    localparam int FRAME = WIDTH * HEIGHT;
    localparam int AW    = $clog2(2 * FRAME);

    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
    localparam logic [AW-1:0] FRAME_A = AW'(FRAME);
    localparam logic [AW-1:0] LAST_A  = AW'(FRAME - 1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [AW-1:0]      exp_idx_reg, exp_idx_next;
    logic               wr_bank_reg, wr_bank_next;
    logic               w_en_reg, w_en_next;
    logic [AW-1:0]      w_addr_reg, w_addr_next;
    logic [PIXEL_W-1:0] w_data_reg, w_data_next;
    logic               frame_done_reg, frame_done_next;
    logic               err_range_reg, err_range_next;
    logic               err_order_reg, err_order_next;
    logic [7:0]         drop_cnt_reg, drop_cnt_next;

    // Coordinate decode. The range test runs at full 16-bit width so large
    // coordinates can never alias into range; the address math then runs
    // at AW bits, which is wide enough for every in-range coordinate.
    logic               in_range;
    logic               is_origin;
    logic [AW-1:0]      row_ext;
    logic [AW-1:0]      col_ext;
    logic [AW-1:0]      lin_idx;
    logic [AW-1:0]      bank_base;
    logic [AW-1:0]      wr_addr;

    always_comb begin
        in_range  = ({16'd0, bus.row_i} < 32'(HEIGHT)) &&
                    ({16'd0, bus.col_i} < 32'(WIDTH));
        is_origin = (bus.row_i == 16'd0) && (bus.col_i == 16'd0);
        row_ext   = AW'(bus.row_i);
        col_ext   = AW'(bus.col_i);
        lin_idx   = row_ext * WIDTH_A + col_ext;
        bank_base = wr_bank_reg ? FRAME_A : '0;
        wr_addr   = bank_base + lin_idx;
    end

    always_ff @(posedge pclk) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            exp_idx_reg    <= '0;
            wr_bank_reg    <= 1'b0;
            w_en_reg       <= 1'b0;
            w_addr_reg     <= '0;
            w_data_reg     <= '0;
            frame_done_reg <= 1'b0;
            err_range_reg  <= 1'b0;
            err_order_reg  <= 1'b0;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            exp_idx_reg    <= exp_idx_next;
            wr_bank_reg    <= wr_bank_next;
            w_en_reg       <= w_en_next;
            w_addr_reg     <= w_addr_next;
            w_data_reg     <= w_data_next;
            frame_done_reg <= frame_done_next;
            err_range_reg  <= err_range_next;
            err_order_reg  <= err_order_next;
            drop_cnt_reg   <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        exp_idx_next    = exp_idx_reg;
        wr_bank_next    = wr_bank_reg;
        w_en_next       = 1'b0;
        w_addr_next     = w_addr_reg;
        w_data_next     = w_data_reg;
        frame_done_next = 1'b0;
        err_range_next  = err_range_reg;
        err_order_next  = err_order_reg;
        drop_cnt_next   = drop_cnt_reg;

        case (state_reg)
            IDLE: begin
                // Only a (0,0) pixel opens a frame; anything else in range
                // is mid-frame traffic we joined late and is skipped.
                if (bus.valid_i) begin
                    if (!in_range) begin
                        err_range_next = 1'b1;
                    end else if (is_origin) begin
                        w_en_next    = 1'b1;
                        w_addr_next  = wr_addr;
                        w_data_next  = bus.pixel_i;
                        exp_idx_next = ONE_A;
                        state_next   = WRITE;
                    end
                end
            end

            WRITE: begin
                if (bus.valid_i) begin
                    if (!in_range) begin
                        err_range_next = 1'b1;
                    end else begin
                        w_en_next   = 1'b1;
                        w_addr_next = wr_addr;
                        w_data_next = bus.pixel_i;
                        if (is_origin) begin
                            // Early (0,0): the source restarted its frame.
                            exp_idx_next   = ONE_A;
                            err_order_next = 1'b1;
                        end else begin
                            if (lin_idx != exp_idx_reg) begin
                                err_order_next = 1'b1;
                            end
                            exp_idx_next = lin_idx + ONE_A;
                        end
                        if (lin_idx == LAST_A) begin
                            frame_done_next = 1'b1;
                            state_next      = FULL;
                        end
                    end
                end
            end

            FULL: begin
                // A swap wins over a simultaneous frame start: that first
                // pixel is lost, but the frame is not counted as dropped.
                if (bus.swap_i) begin
                    wr_bank_next = ~wr_bank_reg;
                    exp_idx_next = '0;
                    state_next   = IDLE;
                end else if (bus.valid_i && is_origin &&
                             (drop_cnt_reg != 8'hFF)) begin
                    drop_cnt_next = drop_cnt_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.w_en_o   = w_en_reg;
    assign bus.w_addr_o = w_addr_reg;
    assign bus.w_data_o = w_data_reg;
    assign wr_bank_o    = wr_bank_reg;
    assign rd_bank_o    = ~wr_bank_reg;
    assign frame_done_o = frame_done_reg;
    assign err_range_o  = err_range_reg;
    assign err_order_o  = err_order_reg;
    assign drop_cnt_o   = drop_cnt_reg;

endmodule

// File: tb/tb_vbuff_writer.sv
// ---------------------------------------------------------------------------
// tb_vbuff_writer
// Directed bench for vbuff_writer on a 4x2 frame. Inputs change on the
// falling edge; outputs are observed on the following falling edge, i.e.
// one rising edge after the stimulus was sampled.
// ---------------------------------------------------------------------------
module tb_vbuff_writer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PW = 12;
    localparam int AW = $clog2(2 * W * H);

    logic       pclk;
    logic       rst_i;
    logic       wr_bank;
    logic       rd_bank;
    logic       frame_done;
    logic       err_range;
    logic       err_order;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    vbuff_writer_if #(.PIXEL_W(PW), .AW(AW)) bus ();

    vbuff_writer #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .PIXEL_W (PW)
    ) dut (
        .pclk         (pclk),
        .rst_i        (rst_i),
        .bus          (bus),
        .wr_bank_o    (wr_bank),
        .rd_bank_o    (rd_bank),
        .frame_done_o (frame_done),
        .err_range_o  (err_range),
        .err_order_o  (err_order),
        .drop_cnt_o   (drop_cnt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; returns on the next falling edge with the
    // registered response visible.
    task automatic cyc(input logic r, input logic v, input int row, input int col,
                       input int px, input logic sw);
        rst_i       = r;
        bus.valid_i = v;
        bus.row_i   = 16'(row);
        bus.col_i   = 16'(col);
        bus.pixel_i = PW'(px);
        bus.swap_i  = sw;
        @(posedge pclk);
        @(negedge pclk);
        $display("txn rst=%0d v=%0d r=%0d c=%0d px=%03h sw=%0d -> en=%0d addr=%0d data=%03h done=%0d bank=%0d erng=%0d eord=%0d drop=%0d",
                 r, v, row, col, px, sw, bus.w_en_o, bus.w_addr_o, bus.w_data_o,
                 frame_done, wr_bank, err_range, err_order, drop_cnt);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_en"},    bus.w_en_o,   0);
        check({tag, "_addr"},  bus.w_addr_o, 0);
        check({tag, "_data"},  bus.w_data_o, 0);
        check({tag, "_done"},  frame_done,   0);
        check({tag, "_wbank"}, wr_bank,      0);
        check({tag, "_rbank"}, rd_bank,      1);
        check({tag, "_erng"},  err_range,    0);
        check({tag, "_eord"},  err_order,    0);
        check({tag, "_drop"},  drop_cnt,     0);
    endtask

    // Out-of-range test vectors: (2,0) and (0,4) are interleaved into an
    // otherwise clean raster.
    int rng_r [10] = '{0, 2, 0, 0, 0, 0, 1, 1, 1, 1};
    int rng_c [10] = '{0, 0, 1, 4, 2, 3, 0, 1, 2, 3};

    initial begin
        rst_i       = 1'b1;
        bus.valid_i = 1'b0;
        bus.row_i   = '0;
        bus.col_i   = '0;
        bus.pixel_i = '0;
        bus.swap_i  = 1'b0;
        @(negedge pclk);

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_reset_state("rst");

        // Frame 0 into bank 0: addresses 0..7, data 0x100..0x107
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, i / W, i % W, 'h100 + i, 0);
            check("f0_en",   bus.w_en_o,   1);
            check("f0_addr", bus.w_addr_o, i);
            check("f0_data", bus.w_data_o, 'h100 + i);
            check("f0_done", frame_done,   (i == 7));
        end
        cyc(0, 0, 0, 0, 0, 1);
        check("swap0_en",    bus.w_en_o,   0);
        check("swap0_hold",  bus.w_addr_o, 7);
        check("swap0_hdata", bus.w_data_o, 'h107);
        check("swap0_wbank", wr_bank,      1);
        check("swap0_rbank", rd_bank,      0);

        // Frame 1 into bank 1: addresses 8..15
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, i / W, i % W, 'h200 + i, 0);
            check("f1_en",   bus.w_en_o,   1);
            check("f1_addr", bus.w_addr_o, 8 + i);
            check("f1_data", bus.w_data_o, 'h200 + i);
            check("f1_done", frame_done,   (i == 7));
        end
        check("f1_erng", err_range, 0);
        check("f1_eord", err_order, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("swap1_wbank", wr_bank, 0);

        // Out-of-range coordinates in bank 0
        for (int k = 0; k < 10; k++) begin
            logic inr;
            int   idx;
            inr = (rng_r[k] < H) && (rng_c[k] < W);
            idx = rng_r[k] * W + rng_c[k];
            cyc(0, 1, rng_r[k], rng_c[k], 'h300 + k, 0);
            check("rng_en", bus.w_en_o, inr);
            if (inr) begin
                check("rng_addr", bus.w_addr_o, idx);
                check("rng_data", bus.w_data_o, 'h300 + k);
                check("rng_done", frame_done,   (idx == 7));
            end
        end
        check("rng_erng", err_range, 1);
        check("rng_eord", err_order, 0);

        // Order error: (0,0),(0,1),(0,3) then the rest of the frame
        cyc(1, 0, 0, 0, 0, 0);
        check_reset_state("rst2");
        cyc(0, 1, 0, 0, 'h400, 0);
        check("ord_addr0", bus.w_addr_o, 0);
        cyc(0, 1, 0, 1, 'h401, 0);
        check("ord_addr1", bus.w_addr_o, 1);
        check("ord_eord1", err_order,    0);
        cyc(0, 1, 0, 3, 'h403, 0);
        check("ord_en3",   bus.w_en_o,   1);
        check("ord_addr3", bus.w_addr_o, 3);
        check("ord_eord3", err_order,    1);
        for (int c = 0; c < W; c++) begin
            cyc(0, 1, 1, c, 'h404 + c, 0);
            check("ord_addr", bus.w_addr_o, 4 + c);
            check("ord_done", frame_done,   (c == 3));
        end

        // FULL: drops counted, other pixels ignored, swap beats (0,0)
        cyc(0, 1, 0, 0, 'h500, 0);
        check("drop1_en",  bus.w_en_o, 0);
        check("drop1_cnt", drop_cnt,   1);
        cyc(0, 1, 0, 1, 'h501, 0);
        check("full_en",   bus.w_en_o, 0);
        check("full_cnt",  drop_cnt,   1);
        cyc(0, 1, 0, 0, 'h502, 0);
        check("drop2_en",  bus.w_en_o, 0);
        check("drop2_cnt", drop_cnt,   2);
        cyc(0, 1, 0, 0, 'h503, 1);
        check("swdrop_en",    bus.w_en_o, 0);
        check("swdrop_cnt",   drop_cnt,   2);
        check("swdrop_wbank", wr_bank,    1);
        // Back in IDLE on bank 1: a fresh (0,0) opens a frame at address 8
        cyc(0, 1, 0, 0, 'h600, 0);
        check("b1_en",   bus.w_en_o,   1);
        check("b1_addr", bus.w_addr_o, 8);
        for (int c = 1; c < W; c++) begin
            cyc(0, 1, 0, c, 'h600 + c, 0);
            check("b1_addr", bus.w_addr_o, 8 + c);
        end

        // Reset arriving with pixel 4: that write must never appear
        cyc(1, 1, 1, 0, 'h604, 0);
        check_reset_state("rst3");
        cyc(0, 0, 0, 0, 0, 0);
        check("post_rst_en", bus.w_en_o, 0);
        cyc(0, 1, 0, 0, 'h700, 0);
        check("post_rst_en0",   bus.w_en_o,   1);
        check("post_rst_addr0", bus.w_addr_o, 0);
        check("post_rst_data0", bus.w_data_o, 'h700);

        // Restart inside a frame: (0,0) again rewrites address 0 in bank 0
        cyc(0, 1, 0, 1, 'h701, 0);
        check("rs_addr1", bus.w_addr_o, 1);
        check("rs_eord1", err_order,    0);
        cyc(0, 1, 0, 0, 'h710, 0);
        check("rs_en",   bus.w_en_o,   1);
        check("rs_addr", bus.w_addr_o, 0);
        check("rs_data", bus.w_data_o, 'h710);
        check("rs_eord", err_order,    1);
        cyc(0, 1, 0, 1, 'h711, 0);
        check("rs_next", bus.w_addr_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
